ram_arbiter: RTL and testbench

- Shares the single-port RAM between two requesters: the instruction-fetch port (if_*) and the load/store port (ls_*).
- Sequences every RAM access: one access in flight at a time.
  - A read uses a 1-cycle registered read path.
  - A write is 8-bit and zero-extended by the RAM.
- Sits between the CPU core and the RAM. It drives the RAM's write_enable/address/data and takes its data_out.

---
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the instruction-fetch port
// (if_*) and the load/store port (ls_*). One access is in flight at a time:
// IDLE (grant) -> ACCESS (RAM samples) -> RESP (read data back) -> IDLE.
// Stores skip RESP.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   if_req/if_addr                     fetch read request
//   if_gnt                             fetch accepted (combinational, IDLE only)
//   if_rvalid/if_rdata                 fetch read data (1-cycle pulse)
//   ls_req/ls_we/ls_addr/ls_wdata      load/store request
//   ls_gnt                             load/store accepted (combinational, IDLE only)
//   ls_rvalid/ls_rdata                 load data (1-cycle pulse, never for stores)
//   ram_we/ram_addr/ram_wdata          registered RAM controls
//   ram_rdata                          RAM data_out (1-cycle registered read)
//
// Build option:
//   ARB_LS_PRIORITY_EN  defined   -> ls always wins a tie, no round-robin pointer
//                       undefined -> round-robin tie-break, ls preferred after reset
module ram_arbiter #(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [DEPTH-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [DEPTH-1:0] ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             ls_gnt,
    output logic             ls_rvalid,
    output logic [31:0]      ls_rdata,
    output logic             ram_we,
    output logic [DEPTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [31:0]      ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    state_t state;
    owner_t owner;
    logic   tie_ls;     // 1 when ls should win a simultaneous request

`ifdef ARB_LS_PRIORITY_EN
    assign tie_ls = 1'b1;
`else
    logic last_if;      // 1 when the most recent grant went to the fetch port

    // Round-robin pointer: the port granted last loses the next tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_if <= 1'b1;
        end else if (if_gnt) begin
            last_if <= 1'b1;
        end else if (ls_gnt) begin
            last_if <= 1'b0;
        end
    end

    assign tie_ls = last_if;
`endif

    // Grant decode: only in IDLE, and suppressed while reset is asserted.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!reset && state == IDLE) begin
            if (if_req && ls_req) begin
                ls_gnt = tie_ls;
                if_gnt = !tie_ls;
            end else begin
                if_gnt = if_req;
                ls_gnt = ls_req;
            end
        end
    end

    // Read data is a straight pass-through; rvalid qualifies it.
    assign if_rdata = ram_rdata;
    assign ls_rdata = ram_rdata;

    // Access sequencer with registered RAM controls and rvalid pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    ram_we <= 1'b0;
                    if (ls_gnt) begin
                        owner     <= OWN_LS;
                        ram_addr  <= ls_addr;
                        ram_we    <= ls_we;
                        ram_wdata <= ls_wdata;
                        state     <= ACCESS;
                    end else if (if_gnt) begin
                        owner     <= OWN_IF;
                        ram_addr  <= if_addr;
                        ram_we    <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // ram_we still high here means this access is a store.
                    ram_we <= 1'b0;
                    if (ram_we) begin
                        owner <= OWN_NONE;
                        state <= IDLE;
                    end else begin
                        if_rvalid <= (owner == OWN_IF);
                        ls_rvalid <= (owner == OWN_LS);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    ram_we <= 1'b0;
                    owner  <= OWN_NONE;
                    state  <= IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    owner  <= OWN_NONE;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: behavioural RAM, shadow memory reference,
// directed scenarios followed by randomized transactions.
module tb_ram_arbiter;

    localparam int unsigned DEPTH = 10;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned WORDS = 1 << DEPTH;

`ifdef ARB_LS_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             if_req;
    logic [DEPTH-1:0] if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [31:0]      if_rdata;
    logic             ls_req;
    logic             ls_we;
    logic [DEPTH-1:0] ls_addr;
    logic [WIDTH-1:0] ls_wdata;
    logic             ls_gnt;
    logic             ls_rvalid;
    logic [31:0]      ls_rdata;
    logic             ram_we;
    logic [DEPTH-1:0] ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [31:0]      ram_rdata;

    int n_vec = 0;
    int n_err = 0;

    ram_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preload pattern: word 5 = 0xAB, every other word unique per address.
    function automatic logic [31:0] pre(input logic [DEPTH-1:0] a);
        if (a == 10'd5) return 32'h0000_00AB;
        return {6'h15, a, 6'h00, a};
    endfunction

    // Behavioural single-port RAM: 8-bit zero-extended write, 1-cycle read.
    logic [31:0] mem [WORDS];
    bit          written [WORDS];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= {24'h0, ram_wdata};
            written[ram_addr] <= 1'b1;
        end
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : pre(ram_addr);
    end

    // Reference view of memory contents, updated from the transactions issued.
    logic [31:0] shadow [WORDS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        if_req = 1'b1;
        ls_req = 1'b1;
        @(negedge clk);
        #1;
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_ls_gnt", 32'(ls_gnt), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
        if_req = 1'b0;
        ls_req = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic drive(input int p, input logic we, input logic [DEPTH-1:0] a,
                         input logic [WIDTH-1:0] d);
        if (p == 0) begin
            if_req  = 1'b1;
            if_addr = a;
        end else begin
            ls_req   = 1'b1;
            ls_we    = we;
            ls_addr  = a;
            ls_wdata = d;
        end
    endtask

    // Wait (bounded) for port p's grant; returns at #1 after the negedge of the grant cycle.
    task automatic wait_gnt(input int p, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if ((p == 0) ? if_gnt : ls_gnt) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // From the grant cycle N: check ACCESS (N+1), response (N+2), and quiet (N+3).
    task automatic follow(input int p, input logic we, input logic [DEPTH-1:0] a,
                          input logic [WIDTH-1:0] d);
        logic [31:0] exp_data;
        exp_data = shadow[a];
        if (we) shadow[a] = {24'h0, d};
        @(negedge clk);
        #1;
        if (p == 0) if_req = 1'b0; else ls_req = 1'b0;
        check("acc_addr", 32'(ram_addr), 32'(a));
        check("acc_we", 32'(ram_we), 32'(we));
        if (we) check("acc_wdata", 32'(ram_wdata), 32'(d));
        check("acc_no_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
        check("acc_no_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
        @(negedge clk);
        #1;
        check("resp_we_low", 32'(ram_we), 32'd0);
        if (we) begin
            check("store_no_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
        end else begin
            check("resp_rvalid", 32'({if_rvalid, ls_rvalid}), (p == 0) ? 32'd2 : 32'd1);
            check("resp_rdata", (p == 0) ? if_rdata : ls_rdata, exp_data);
        end
        @(negedge clk);
        #1;
        check("pulse_end", 32'({if_rvalid, ls_rvalid}), 32'd0);
    endtask

    task automatic transact(input int p, input logic we, input logic [DEPTH-1:0] a,
                            input logic [WIDTH-1:0] d);
        bit ok;
        @(negedge clk);
        drive(p, we, a, d);
        wait_gnt(p, ok);
        check("gnt_seen", 32'(ok), 32'd1);
        if (!ok) begin
            if_req = 1'b0;
            ls_req = 1'b0;
            return;
        end
        check("gnt_excl", 32'((p == 0) ? ls_gnt : if_gnt), 32'd0);
        follow(p, we, a, d);
    endtask

    initial begin
        bit ok;
        int k;
        bit exp_ls;
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        for (int i = 0; i < int'(WORDS); i++) shadow[i] = pre(DEPTH'(i));

        // Fetch of preloaded word 5.
        do_reset();
        transact(0, 1'b0, 10'h005, 8'h00);

        // Store to top address, then load it back (zero-extended).
        transact(1, 1'b1, 10'h3FF, 8'hC3);
        transact(1, 1'b0, 10'h3FF, 8'h00);

        // Both requests held continuously from reset.
        do_reset();
        @(negedge clk);
        drive(0, 1'b0, 10'h011, 8'h00);
        drive(1, 1'b0, 10'h022, 8'h00);
        for (int g = 0; g < 4; g++) begin
            ok = 1'b0;
            for (k = 0; k < 16; k++) begin
                #1;
                if (if_gnt || ls_gnt) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("tie_gnt_seen", 32'(ok), 32'd1);
            if (g > 0) check("tie_regrant_lat", 32'(k), 32'd0);
            exp_ls = PRIO ? 1'b1 : (g % 2 == 0);
            check("tie_winner", 32'({if_gnt, ls_gnt}), exp_ls ? 32'd1 : 32'd2);
            @(negedge clk);
            @(negedge clk);
            #1;
            check("tie_route", 32'({if_rvalid, ls_rvalid}), exp_ls ? 32'd1 : 32'd2);
            check("tie_rdata", exp_ls ? ls_rdata : if_rdata,
                  exp_ls ? shadow[10'h022] : shadow[10'h011]);
            @(negedge clk);
        end
        if_req = 1'b0;
        ls_req = 1'b0;

        // Fetch request arriving during the load's RESP cycle waits for IDLE.
        do_reset();
        @(negedge clk);
        drive(1, 1'b0, 10'h033, 8'h00);
        wait_gnt(1, ok);
        check("resp_block_gnt", 32'(ok), 32'd1);
        @(negedge clk);
        ls_req = 1'b0;
        @(negedge clk);
        drive(0, 1'b0, 10'h044, 8'h00);
        #1;
        check("resp_block_if_gnt", 32'(if_gnt), 32'd0);
        check("resp_block_ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("resp_block_ls_rdata", ls_rdata, shadow[10'h033]);
        @(negedge clk);
        #1;
        check("resp_block_first_idle", 32'(if_gnt), 32'd1);
        follow(0, 1'b0, 10'h044, 8'h00);

        // Reset during the ACCESS cycle of a load.
        @(negedge clk);
        drive(1, 1'b0, 10'h055, 8'h00);
        wait_gnt(1, ok);
        check("midrst_gnt", 32'(ok), 32'd1);
        @(negedge clk);
        ls_req = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_we", 32'(ram_we), 32'd0);
        check("midrst_addr", 32'(ram_addr), 32'd0);
        check("midrst_rvalid", 32'(ls_rvalid), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("midrst_no_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
        end
        // Arbiter is back in IDLE: an immediate request is granted at once.
        drive(0, 1'b0, 10'h066, 8'h00);
        #1;
        check("midrst_idle_gnt", 32'(if_gnt), 32'd1);
        follow(0, 1'b0, 10'h066, 8'h00);

        // Address wrap boundary: top and bottom words stay distinct.
        transact(0, 1'b0, 10'h3FF, 8'h00);
        transact(0, 1'b0, 10'h000, 8'h00);

        // Randomized single-port transactions over a small address window.
        for (int t = 0; t < 40; t++) begin
            int p;
            logic we;
            logic [DEPTH-1:0] a;
            logic [WIDTH-1:0] d;
            p  = int'($urandom_range(0, 1));
            we = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            a  = ($urandom_range(0, 3) == 0) ? 10'h3FF : DEPTH'($urandom_range(0, 7));
            d  = WIDTH'($urandom);
            transact(p, we, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
